// File: rtl/ifid_stage.sv
// IF/ID pipeline register with stall, flush and halt control plus a stall watchdog.
// Define IFID_STALL_CNT_EN to add the StallCount port and its total-stall counter.
module ifid_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Halt,
  input  logic [15:0] IF_instr,
  input  logic [15:0] IF_pcInc,
  output logic [15:0] ID_instr,
  output logic [15:0] ID_pcInc,
  output logic        ID_valid,
  output logic        PC_WrEn,
  output logic        IDEX_Bubble,
  output logic        Halted,
  output logic        StallErr
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0] StallCount
`endif
);

  typedef enum logic [1:0] {StRun, StStall, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcinc_q, pcinc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [2:0]  cons_q, cons_d;
  logic        advance;

  assign ID_instr    = instr_q;
  assign ID_pcInc    = pcinc_q;
  assign ID_valid    = valid_q;
  assign StallErr    = err_q;
  assign Halted      = (state_q == StHalt);
  assign advance     = valid_q & ~Stall & ~Halted;
  assign PC_WrEn     = ~Halted & ~Stall & ~(Halt & valid_q);
  assign IDEX_Bubble = Stall | ~valid_q | Halted;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pcinc_d = pcinc_q;
    valid_d = valid_q;
    if (!Halted) begin
      if (Stall) begin
        state_d = StStall;
      end else if (Halt & advance) begin
        state_d = StHalt;
        instr_d = 16'h0000;
        valid_d = 1'b0;
      end else if (Flush) begin
        // pcInc is left as-is; it is meaningless while ID holds a bubble
        state_d = StRun;
        instr_d = 16'h0000;
        valid_d = 1'b0;
      end else begin
        state_d = StRun;
        instr_d = IF_instr;
        pcinc_d = IF_pcInc;
        valid_d = 1'b1;
      end
    end
  end

  // Watchdog counts consecutive stalls regardless of state and trips on the 8th.
  always_comb begin
    cons_d = 3'd0;
    if (Stall) begin
      cons_d = (cons_q == 3'd7) ? 3'd7 : cons_q + 3'd1;
    end
    err_d = err_q | (Stall & (cons_q == 3'd7));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      instr_q <= 16'h0000;
      pcinc_q <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cons_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pcinc_q <= pcinc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cons_q  <= cons_d;
    end
  end

`ifdef IFID_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Stall && !Halted && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign StallCount = cnt_q;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// Self-checking bench for ifid_stage: directed scenarios plus randomized traffic against a
// behavioural model; covers StallCount when IFID_STALL_CNT_EN is defined.
module tb_ifid_stage;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, halt;
  logic [15:0] if_instr, if_pc;
  logic [15:0] id_instr, id_pc;
  logic        id_valid, pc_wren, idex_bubble, halted, stall_err;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int checks;
  int failures;

  ifid_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Stall      (stall),
    .Flush      (flush),
    .Halt       (halt),
    .IF_instr   (if_instr),
    .IF_pcInc   (if_pc),
    .ID_instr   (id_instr),
    .ID_pcInc   (id_pc),
    .ID_valid   (id_valid),
    .PC_WrEn    (pc_wren),
    .IDEX_Bubble(idex_bubble),
    .Halted     (halted),
    .StallErr   (stall_err)
`ifdef IFID_STALL_CNT_EN
    ,
    .StallCount (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what ID must hold, plus an unbounded stall-streak length.
  logic [15:0] m_instr, m_pc;
  logic        m_valid, m_halted, m_err;
  int          m_streak;
  int          m_total;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_instr  <= 16'h0000;
      m_pc     <= 16'h0000;
      m_valid  <= 1'b0;
      m_halted <= 1'b0;
      m_err    <= 1'b0;
      m_streak <= 0;
      m_total  <= 0;
    end else begin
      m_streak <= stall ? m_streak + 1 : 0;
      if (stall && (m_streak + 1 >= 8)) m_err <= 1'b1;
      if (stall && !m_halted && m_total < 65535) m_total <= m_total + 1;
      if (!m_halted && !stall) begin
        if (halt && m_valid) begin
          m_halted <= 1'b1;
          m_instr  <= 16'h0000;
          m_valid  <= 1'b0;
        end else if (flush) begin
          m_instr <= 16'h0000;
          m_valid <= 1'b0;
        end else begin
          m_instr <= if_instr;
          m_pc    <= if_pc;
          m_valid <= 1'b1;
        end
      end
    end
  end

  // Compare every cycle, mid-period, against the model.
  always @(negedge clk) begin
    chk("id_instr", {16'h0, id_instr}, {16'h0, m_instr});
    chk("id_pcinc", {16'h0, id_pc}, {16'h0, m_pc});
    chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
    chk("halted", {31'h0, halted}, {31'h0, m_halted});
    chk("stall_err", {31'h0, stall_err}, {31'h0, m_err});
    chk("pc_wren", {31'h0, pc_wren}, {31'h0, (!m_halted && !stall && !(halt && m_valid))});
    chk("idex_bubble", {31'h0, idex_bubble}, {31'h0, (stall || !m_valid || m_halted)});
`ifdef IFID_STALL_CNT_EN
    chk("stall_count", {16'h0, stall_count}, m_total);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic h,
                       input logic [15:0] ins, input logic [15:0] pc);
    stall    = s;
    flush    = f;
    halt     = h;
    if_instr = ins;
    if_pc    = pc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("rst_instr", {16'h0, id_instr}, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_pcwren", {31'h0, pc_wren}, 32'h1);
    chk("rst_bubble", {31'h0, idex_bubble}, 32'h1);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // First load after reset
    drive(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0002);
    step();
    chk("load_instr", {16'h0, id_instr}, 32'h1234);
    chk("load_pcinc", {16'h0, id_pc}, 32'h0002);
    chk("load_valid", {31'h0, id_valid}, 32'h1);
    chk("load_bubble", {31'h0, idex_bubble}, 32'h0);

    // Two stall cycles with IF changing underneath
    drive(1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h0004);
    #1;
    chk("stall_pcwren", {31'h0, pc_wren}, 32'h0);
    step();
    chk("stall1_instr", {16'h0, id_instr}, 32'h1234);
    chk("stall1_bubble", {31'h0, idex_bubble}, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 16'hBBBB, 16'h0006);
    step();
    chk("stall2_instr", {16'h0, id_instr}, 32'h1234);
    chk("stall2_pcwren", {31'h0, pc_wren}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 16'hBBBB, 16'h0006);
    step();
    chk("unstall_instr", {16'h0, id_instr}, 32'hBBBB);

    // Flush squashes; flush under stall is ignored
    drive(1'b0, 1'b1, 1'b0, 16'hCCCC, 16'h0008);
    step();
    chk("flush_instr", {16'h0, id_instr}, 32'h0);
    chk("flush_valid", {31'h0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 16'hDDDD, 16'h000A);
    step();
    drive(1'b1, 1'b1, 1'b0, 16'hEEEE, 16'h000C);
    step();
    chk("flush_stall_instr", {16'h0, id_instr}, 32'hDDDD);
    chk("flush_stall_valid", {31'h0, id_valid}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    do_reset();

    // Watchdog: 7 stalls stay clean, 8 consecutive trip it
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h1111, 16'h0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h1111, 16'h0);
    step();
    chk("err_after7", {31'h0, stall_err}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h2222, 16'h0);
      step();
      if (i == 6) chk("err_at7th", {31'h0, stall_err}, 32'h0);
    end
    chk("err_at8th", {31'h0, stall_err}, 32'h1);
`ifdef IFID_STALL_CNT_EN
    chk("stall_count15", {16'h0, stall_count}, 32'd15);
`endif

    // Halt: PC frozen immediately, halted until reset
    drive(1'b0, 1'b0, 1'b0, 16'h3333, 16'h0010);
    step();
    drive(1'b0, 1'b0, 1'b1, 16'h4444, 16'h0012);
    #1;
    chk("halt_pcwren", {31'h0, pc_wren}, 32'h0);
    step();
    chk("halted_next", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 22; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom));
      step();
    end
    chk("halted_held", {31'h0, halted}, 32'h1);
    chk("halted_instr", {16'h0, id_instr}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_halted", {31'h0, halted}, 32'h0);
    chk("async_err", {31'h0, stall_err}, 32'h0);
    step();
    rst_n = 1'b1;

    // Async reset in the middle of a stall
    drive(1'b0, 1'b0, 1'b0, 16'h5555, 16'h0020);
    step();
    drive(1'b1, 1'b0, 1'b0, 16'h6666, 16'h0022);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_instr", {16'h0, id_instr}, 32'h0);
    chk("async_pcinc", {16'h0, id_pc}, 32'h0);
    chk("async_valid", {31'h0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("async_pcwren", {31'h0, pc_wren}, 32'h1);
    step();
    rst_n = 1'b1;

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 29) == 0), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 79) == 0) begin
        #3 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
